// File: rtl/instr_fetch_if.sv
// Signal bundle between the fetch stage and its environment: instruction-memory
// request/response channels, the core-facing instruction handshake and redirects.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues in-order word fetches, buffers returned words in a
// small FIFO for the core, and flushes/discards stale work on control-flow redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;

    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [31:0]      rspPc_q, rspPc_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic             running_q;
    logic [31:0]      dataMem_q [DEPTH];
    logic [31:0]      pcMem_q [DEPTH];

    logic [CNT_W:0]   inUse;
    logic [CNT_W-1:0] rspDec;
    logic [31:0]      redirectTarget;
    logic             reqValid;
    logic             accept;
    logic             fifoValid;
    logic             push;
    logic             pop;

    // Credit check: buffered words plus in-flight requests may never exceed the FIFO.
    assign inUse          = {1'b0, count_q} + {1'b0, outstanding_q};
    assign reqValid       = running_q && !bus.redirect_valid && (inUse < DEPTH_W);
    assign accept         = reqValid && bus.imem_req_ready;
    assign fifoValid      = (count_q != '0);
    assign push           = bus.imem_rsp_valid && (discard_q == '0) && !bus.redirect_valid;
    assign pop            = fifoValid && bus.instr_ready && !bus.redirect_valid;
    assign rspDec         = CNT_W'(bus.imem_rsp_valid);
    assign redirectTarget = bus.redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (bus.redirect_valid) begin
            // Everything still in flight is stale; a response landing now is already dropped.
            fetchPc_d     = redirectTarget;
            rspPc_d       = redirectTarget;
            wrPtr_d       = '0;
            rdPtr_d       = '0;
            count_d       = '0;
            outstanding_d = outstanding_q - rspDec;
            discard_d     = outstanding_q - rspDec;
        end else begin
            if (accept) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
                rspPc_d = rspPc_q + 32'd4;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            outstanding_d = outstanding_q + CNT_W'(accept) - rspDec;
            if (bus.imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            running_q     <= 1'b0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            running_q     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dataMem_q[wrPtr_q] <= bus.imem_rsp_data;
            pcMem_q[wrPtr_q]   <= rspPc_q;
        end
    end

    assign bus.imem_req_valid = reqValid;
    assign bus.imem_req_addr  = fetchPc_q;
    assign bus.instr_valid    = fifoValid;
    assign bus.instr          = fifoValid ? dataMem_q[rdPtr_q] : NOP;
    assign bus.instr_pc       = fifoValid ? pcMem_q[rdPtr_q] : 32'h0000_0000;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed address/PC expectations.
module tb_instr_fetch;
    localparam int          DEPTH = 4;
    localparam int          HALF  = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct {
        int          due;
        logic [31:0] data;
    } memEntry_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } inflight_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } fifoEntry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #HALF clk = ~clk;

    int          cycle;
    int          memLat;
    logic [31:0] dataXor;
    int          passCount;
    int          checkCount;
    int          redirCyc;

    memEntry_t   memQ[$];
    inflight_t   inflQ[$];
    fifoEntry_t  fifoQ[$];
    logic [31:0] mFetchPc;
    bit          mStarted;

    logic [31:0] reqLog[$];
    int          reqCyc[$];
    logic [31:0] outLog[$];
    int          outCyc[$];

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
    endtask

    task automatic modelReset();
        fifoQ.delete();
        inflQ.delete();
        mFetchPc = 32'h0000_0000;
        mStarted = 1'b0;
    endtask

    // Expected outputs come from the model queues: a request is offered only while
    // buffered plus in-flight words leave room, and the head of fifoQ is what the core sees.
    task automatic checkOutput();
        logic expReq;
        expReq = mStarted && !bus.redirect_valid && ((fifoQ.size() + inflQ.size()) < DEPTH);
        checkEq("req_valid", 32'(bus.imem_req_valid), 32'(expReq));
        checkEq("req_addr", bus.imem_req_addr, mFetchPc);
        if (fifoQ.size() > 0) begin
            checkEq("instr_valid", 32'(bus.instr_valid), 32'd1);
            checkEq("instr", bus.instr, fifoQ[0].data);
            checkEq("instr_pc", bus.instr_pc, fifoQ[0].pc);
        end else begin
            checkEq("instr_valid", 32'(bus.instr_valid), 32'd0);
            checkEq("instr", bus.instr, NOP);
            checkEq("instr_pc", bus.instr_pc, 32'h0000_0000);
        end
    endtask

    task automatic modelStep();
        bit         redir;
        bit         expReq;
        inflight_t  f;
        fifoEntry_t e;
        redir  = bus.redirect_valid;
        expReq = mStarted && !redir && ((fifoQ.size() + inflQ.size()) < DEPTH);
        if (fifoQ.size() > 0 && bus.instr_ready && !redir) void'(fifoQ.pop_front());
        if (bus.imem_rsp_valid) begin
            if (inflQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL rsp_unexpected (cycle %0d): response with no request in flight", cycle);
            end else begin
                f = inflQ.pop_front();
                if (!f.stale && !redir) begin
                    if (fifoQ.size() >= DEPTH) begin
                        checkCount++;
                        $display("[TB] FAIL fifo_overflow (cycle %0d): push with %0d entries", cycle, fifoQ.size());
                    end else begin
                        e.data = bus.imem_rsp_data;
                        e.pc   = f.addr;
                        fifoQ.push_back(e);
                    end
                end
            end
        end
        if (redir) begin
            fifoQ.delete();
            foreach (inflQ[i]) inflQ[i].stale = 1'b1;
            mFetchPc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else if (expReq && bus.imem_req_ready) begin
            f.addr  = mFetchPc;
            f.stale = 1'b0;
            inflQ.push_back(f);
            mFetchPc = mFetchPc + 32'd4;
        end
        mStarted = 1'b1;
    endtask

    always @(negedge clk) begin
        memEntry_t m;
        if (!rst_n) modelReset();
        checkOutput();
        if (rst_n) begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                m.due  = cycle + memLat;
                m.data = bus.imem_req_addr ^ dataXor;
                memQ.push_back(m);
                reqLog.push_back(bus.imem_req_addr);
                reqCyc.push_back(cycle);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                outLog.push_back(bus.instr_pc);
                outCyc.push_back(cycle);
            end
            modelStep();
        end
    end

    task automatic applyStimulus(input bit reqRdy, input bit iRdy, input bit redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        cycle++;
        bus.imem_req_ready = reqRdy;
        bus.instr_ready    = iRdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        if (!rst_n) memQ.delete();
        if (memQ.size() > 0 && memQ[0].due == cycle) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memQ[0].data;
            void'(memQ.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic clearLogs();
        reqLog.delete();
        reqCyc.delete();
        outLog.delete();
        outCyc.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        memQ.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        cycle = 0;
        clearLogs();
    endtask

    task automatic checkResetLiterals(input string tag);
        checkEq({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        checkEq({tag, "_req_addr"}, bus.imem_req_addr, 32'h0000_0000);
        checkEq({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        checkEq({tag, "_instr"}, bus.instr, 32'h0000_0013);
        checkEq({tag, "_instr_pc"}, bus.instr_pc, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        cycle      = 0;
        memLat     = 1;
        dataXor    = 32'h0;
        passCount  = 0;
        checkCount = 0;

        // Reset state, then streaming with a 1-cycle memory returning the address as data.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkResetLiterals("reset");
        rst_n = 1'b1;
        cycle = 0;
        clearLogs();
        repeat (12) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("stream_out_count", 32'(outLog.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkEq("stream_pc", outLog[i], 32'(4 * i));
            checkEq("stream_cycle", 32'(outCyc[i]), 32'(3 + i));
        end

        // Core stalled: exactly DEPTH requests, then drain in order and resume at 0x10.
        doReset();
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkEq("stall_req_count", 32'(reqLog.size()), 32'd4);
        checkEq("stall_req_last", reqLog[3], 32'h0000_000C);
        outLog.delete();
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("stall_drain_count", 32'(outLog.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) checkEq("stall_drain_pc", outLog[i], 32'(4 * i));
        checkEq("stall_resume_addr", reqLog[4], 32'h0000_0010);

        // Toggling memory ready with 3-cycle latency and an irregular consumer.
        doReset();
        memLat  = 3;
        dataXor = 32'hA5A5_0000;
        for (int c = 0; c < 40; c++) applyStimulus((cycle % 2) == 0, (cycle % 3) != 2, 1'b0, 32'h0);
        checkEq("toggle_req_count", 32'(reqLog.size() >= 8), 32'd1);
        checkEq("toggle_out_count", 32'(outLog.size() >= 6), 32'd1);
        for (int i = 0; i < reqLog.size(); i++) checkEq("toggle_req_addr", reqLog[i], 32'(4 * i));
        for (int i = 0; i < outLog.size(); i++) checkEq("toggle_out_pc", outLog[i], 32'(4 * i));

        // Redirect with words buffered and requests in flight (3-cycle memory).
        doReset();
        dataXor = 32'h0;
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1002);
        redirCyc = cycle;
        clearLogs();
        repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("redir_req_addr", reqLog[0], 32'h0000_1000);
        checkEq("redir_req_cycle", 32'(reqCyc[0]), 32'(redirCyc + 1));
        checkEq("redir_out_pc0", outLog[0], 32'h0000_1000);
        checkEq("redir_out_pc1", outLog[1], 32'h0000_1004);

        // Redirect coinciding with a response and a pop, 1-cycle memory latency.
        doReset();
        memLat = 1;
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000);
        redirCyc = cycle;
        clearLogs();
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("redir2_req_cycle", 32'(reqCyc[0]), 32'(redirCyc + 1));
        checkEq("redir2_out_pc", outLog[0], 32'h0000_2000);
        checkEq("redir2_out_cycle", 32'(outCyc[0]), 32'(redirCyc + 3));

        // Back-to-back redirects: only the last target is fetched.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_4007);
        clearLogs();
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("b2b_req_addr", reqLog[0], 32'h0000_4004);
        checkEq("b2b_out_pc", outLog[0], 32'h0000_4004);

        // Address wrap at the top of the address space.
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        clearLogs();
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("wrap_req0", reqLog[0], 32'hFFFF_FFF8);
        checkEq("wrap_req1", reqLog[1], 32'hFFFF_FFFC);
        checkEq("wrap_req2", reqLog[2], 32'h0000_0000);
        checkEq("wrap_out2", outLog[2], 32'h0000_0000);

        // Asynchronous reset mid-stream: outputs return to reset values between edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkResetLiterals("async_rst");
        doReset();
        repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkEq("post_rst_out_pc", outLog[0], 32'h0000_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
